// File: rtl/hdmi_ctrl_axil_slave_regs.sv
// AXI4-Lite register file for the HDMI controller: NUM_REGS 32-bit control registers
// with per-register write pulses. Independent single-outstanding write and read channels.
module hdmi_ctrl_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] REG_RESET_VALUE = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int SW     = DW / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_e;

  // Any address bit above the register index field marks the access unmapped.
  function automatic logic addr_mapped(input logic [AW-1:0] a);
    logic [AW-1:0] hi;
    hi = a >> (2 + IDX_W);
    return (hi == '0);
  endfunction

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  w_state_e              w_state_q;
  logic                  aw_held_q, w_held_q;
  logic [AW-1:0]         awaddr_q;
  logic [DW-1:0]         wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [DW-1:0]         regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q;
  logic                  arready_q, rvalid_q;
  logic [DW-1:0]         rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic [AW-1:0]         wr_addr_eff;
  logic [DW-1:0]         wr_data_eff;
  logic [SW-1:0]         wr_strb_eff;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DW-1:0]         wr_merged_d;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Combine held and same-edge AW/W beats into the effective write request.
  always_comb begin
    aw_hs       = S_AXI_AWVALID && awready_q;
    w_hs        = S_AXI_WVALID && wready_q;
    ar_hs       = S_AXI_ARVALID && arready_q;
    have_aw     = aw_held_q || aw_hs;
    have_w      = w_held_q || w_hs;
    wr_addr_eff = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wr_data_eff = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb_eff = w_hs ? S_AXI_WSTRB : wstrb_q;
    wr_idx      = wr_addr_eff[2 +: IDX_W];
    rd_idx      = S_AXI_ARADDR[2 +: IDX_W];
    wr_merged_d = merge_bytes(regs_q[wr_idx], wr_data_eff, wr_strb_eff);
  end

  // Write channel FSM: collects AW and W, commits the register and issues B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET_VALUE;
    end else begin
      pulse_q <= '0;
      case (w_state_q)
        W_COLLECT: begin
          if (aw_hs) begin
            awaddr_q  <= S_AXI_AWADDR;
            aw_held_q <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
            w_held_q <= 1'b1;
            wready_q <= 1'b0;
          end
          if (have_aw && have_w) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
            if (addr_mapped(wr_addr_eff)) begin
              regs_q[wr_idx]  <= wr_merged_d;
              pulse_q[wr_idx] <= 1'b1;
              bresp_q         <= RESP_OKAY;
            end else begin
              bresp_q <= RESP_SLVERR;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_COLLECT;
          end
        end
        default: begin
          w_state_q <= W_COLLECT;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Read channel: samples the pre-edge register value, holds it until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (rvalid_q) begin
      if (S_AXI_RREADY) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end
    end else if (ar_hs) begin
      rvalid_q  <= 1'b1;
      arready_q <= 1'b0;
      if (addr_mapped(S_AXI_ARADDR)) begin
        rdata_q <= regs_q[rd_idx];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[DW*g +: DW] = regs_q[g];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_hdmi_ctrl_axil_slave_regs.sv
// Randomized bench for hdmi_ctrl_axil_slave_regs: a cycle-level transaction model of the
// register file is checked against the DUT every cycle, plus literal directed checks.
module tb_hdmi_ctrl_axil_slave_regs;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic [32*NR-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  hdmi_ctrl_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(NR),
                              .REG_RESET_VALUE(32'h0)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: transaction view of the register file.
  logic [31:0]   m_regs [NR];
  logic          m_awready, m_wready, m_bvalid, m_rvalid, m_live = 1'b0;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;
  logic [NR-1:0] m_pulse;
  logic [5:0]    p_addr;
  logic [31:0]   p_data;
  logic [3:0]    p_strb;
  bit m_aw_fire, m_w_fire, m_ar_fire, m_b_fire, m_r_fire;

  always @(posedge clk) begin
    m_aw_fire = 0; m_w_fire = 0; m_ar_fire = 0; m_b_fire = 0; m_r_fire = 0;
    if (areset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_rvalid = 1'b0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0; m_pulse = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_pulse   = '0;
      m_aw_fire = awvalid && m_awready;
      m_w_fire  = wvalid && m_wready;
      m_ar_fire = arvalid && !m_rvalid;
      m_b_fire  = m_bvalid && bready;
      m_r_fire  = m_rvalid && rready;
      if (m_r_fire) m_rvalid = 1'b0;
      else if (m_ar_fire) begin
        m_rvalid = 1'b1;
        if (araddr < 4 * NR) begin m_rdata = m_regs[araddr / 4]; m_rresp = 2'b00; end
        else begin m_rdata = 32'h0; m_rresp = 2'b10; end
      end
      if (m_b_fire) begin
        m_bvalid = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
      end else if (!m_bvalid) begin
        if (m_aw_fire) begin p_addr = awaddr; m_awready = 1'b0; end
        if (m_w_fire) begin p_data = wdata; p_strb = wstrb; m_wready = 1'b0; end
        if (!m_awready && !m_wready) begin
          m_bvalid = 1'b1;
          if (p_addr < 4 * NR) begin
            for (int b = 0; b < 4; b++)
              if (p_strb[b]) m_regs[p_addr / 4][8*b +: 8] = p_data[8*b +: 8];
            m_pulse[p_addr / 4] = 1'b1;
            m_bresp = 2'b00;
          end else m_bresp = 2'b10;
        end
      end
    end
  end

  logic [32*NR-1:0] exp_out;
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < NR; i++) exp_out[32*i +: 32] = m_regs[i];
      check("awready", S_AXI_AWREADY, m_awready);
      check("wready", S_AXI_WREADY, m_wready);
      check("bvalid", S_AXI_BVALID, m_bvalid);
      check("arready", S_AXI_ARREADY, !m_rvalid);
      check("rvalid", S_AXI_RVALID, m_rvalid);
      if (m_bvalid) check("bresp", S_AXI_BRESP, m_bresp);
      if (m_rvalid) begin
        check("rdata", S_AXI_RDATA, m_rdata);
        check("rresp", S_AXI_RRESP, m_rresp);
      end
      check("reg_out", reg_out, exp_out);
      check("reg_wr_pulse", reg_wr_pulse, m_pulse);
    end
  end

  logic [1:0]  last_bresp;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  bit          rand_ready = 0;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input bit wait_b);
    fork
      begin
        int n = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!m_aw_fire && n < 100);
        if (!m_aw_fire) timeout("aw_handshake");
        awvalid = 1'b0;
      end
      begin
        int n = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!m_w_fire && n < 100);
        if (!m_w_fire) timeout("w_handshake");
        wvalid = 1'b0;
      end
    join
    if (wait_b) begin
      int n = 0;
      check("bvalid_latency", S_AXI_BVALID, 1'b1);
      last_bresp = S_AXI_BRESP;
      do begin @(posedge clk); #1; n++; end while (!m_b_fire && n < 100);
      if (!m_b_fire) timeout("b_handshake");
    end
  endtask

  task automatic do_read(input logic [5:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!m_ar_fire && n < 100);
    if (!m_ar_fire) timeout("ar_handshake");
    arvalid = 1'b0;
    last_rdata = S_AXI_RDATA;
    last_rresp = S_AXI_RRESP;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!m_r_fire && n < 100);
    if (!m_r_fire) timeout("r_handshake");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wvals [4];
    wvals[0] = 32'h0101FFFF; wvals[1] = 32'hABCD0001;
    wvals[2] = 32'hDEAD0011; wvals[3] = 32'hBEEF0011;
    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // 1: reset values and reads of every register
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_rresp", S_AXI_RRESP, 2'b00);
    check("rst_bresp", S_AXI_BRESP, 2'b00);
    check("rst_awready", S_AXI_AWREADY, 1'b1);
    for (int i = 0; i < NR; i++) begin
      do_read(6'(4 * i));
      check("t1_rdata", last_rdata, 32'h0);
      check("t1_rresp", last_rresp, 2'b00);
    end

    // 2: write all four with AW/W together, read back
    for (int i = 0; i < NR; i++) begin
      do_write(6'(4 * i), wvals[i], 4'hF, 0, 0, 1);
      check("t2_bresp", last_bresp, 2'b00);
    end
    for (int i = 0; i < NR; i++) begin
      do_read(6'(4 * i));
      check("t2_rdata", last_rdata, wvals[i]);
    end

    // 3: W before AW, then AW before W, partial strobe
    do_write(6'h08, 32'hFFFFFFFF, 4'hF, 3, 0, 1);
    do_write(6'h08, 32'h12345678, 4'h3, 0, 2, 1);
    do_read(6'h08);
    check("t3_strobe", last_rdata, 32'hFFFF5678);

    // 4: B back-pressure stalls a second write; R back-pressure holds data
    bready = 1'b0;
    fork
      do_write(6'h0C, 32'hCAFE0001, 4'hF, 0, 0, 1);
      begin repeat (2) begin @(posedge clk); #1; end do_write(6'h00, 32'h00000077, 4'h1, 0, 0, 1); end
      begin
        repeat (6) begin @(posedge clk); #1; end
        check("t4_bvalid_held", S_AXI_BVALID, 1'b1);
        check("t4_awready_low", S_AXI_AWREADY, 1'b0);
        check("t4_bresp_held", S_AXI_BRESP, 2'b00);
        bready = 1'b1;
      end
    join
    rready = 1'b0;
    fork
      do_read(6'h0C);
      begin
        repeat (6) begin @(posedge clk); #1; end
        check("t4_arready_low", S_AXI_ARREADY, 1'b0);
        check("t4_rdata_held", S_AXI_RDATA, 32'hCAFE0001);
        rready = 1'b1;
      end
    join
    check("t4_rdata", last_rdata, 32'hCAFE0001);

    // 5: unmapped address
    do_write(6'h10, 32'h99999999, 4'hF, 0, 0, 1);
    check("t5_bresp", last_bresp, 2'b10);
    do_read(6'h10);
    check("t5_rresp", last_rresp, 2'b10);
    check("t5_rdata", last_rdata, 32'h0);

    // 6: same-edge read and write of one register
    fork
      do_write(6'h04, 32'h55AA55AA, 4'hF, 0, 0, 1);
      do_read(6'h04);
    join
    check("t6_old", last_rdata, 32'hABCD0001);
    do_read(6'h04);
    check("t6_new", last_rdata, 32'h55AA55AA);

    // 6b: reset while the write response is pending
    bready = 1'b0;
    do_write(6'h08, 32'h0BADF00D, 4'hF, 0, 0, 0);
    @(posedge clk); #1 areset = 1'b1;
    @(posedge clk); #1 areset = 1'b0;
    bready = 1'b1;
    check("t6_rst_bvalid", S_AXI_BVALID, 1'b0);
    check("t6_rst_regs", reg_out, 128'h0);

    // Random traffic with random back-pressure
    rand_ready = 1;
    for (int it = 0; it < 300; it++) begin
      fork
        do_write(6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
        begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          do_read(6'($urandom_range(0, 31)));
        end
      join
    end
    rand_ready = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
